// File: rtl/pipe_pkg.sv
// Shared RV32 pipeline types: MEM/WB payload layout and the widths derived from it.
package pipe_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [XLEN-1:0]       mem_data;
      logic [XLEN-1:0]       alu_result;
      logic [REG_ADDR_W-1:0] rd;
   } mem_wb_data_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } mem_wb_ctrl_t;

   localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
   localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: valid bit plus data and control registers.
// Priority: flush, then load, then clear; control is zeroed whenever valid drops.
module pipe_slot #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // NOTE: data is reset too, so the output bus is defined (zero) straight out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         ctrl  <= load_ctrl;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, flush and optional
// 2-entry skid buffer that breaks the combinational ready path from downstream.
module pipe_stage_skid import pipe_pkg::*; #(
   parameter int DATA_W = MEM_WB_DATA_W,
   parameter int CTRL_W = MEM_WB_CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              main_valid;
   logic              main_load;
   logic              main_clear;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] main_load_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [CTRL_W-1:0] main_load_ctrl;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_valid;
         logic              skid_load;
         logic [DATA_W-1:0] skid_data;
         logic [CTRL_W-1:0] skid_ctrl;

         // Ready depends only on the skid register, never on out_ready.
         assign in_ready       = !skid_valid;
         assign skid_load      = in_xfer & main_valid & !out_xfer;
         assign main_load      = (out_xfer & skid_valid) | (in_xfer & (!main_valid | out_xfer));
         assign main_load_data = skid_valid ? skid_data : in_data;
         assign main_load_ctrl = skid_valid ? skid_ctrl : in_ctrl;
         assign main_clear     = out_xfer;

         pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .load      (skid_load),
            .clear     (out_xfer & skid_valid),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (skid_valid),
            .data      (skid_data),
            .ctrl      (skid_ctrl)
         );
      end else begin : g_direct
         assign in_ready       = !main_valid | out_ready;
         assign main_load      = in_xfer;
         assign main_load_data = in_data;
         assign main_load_ctrl = in_ctrl;
         assign main_clear     = out_xfer;
      end
   endgenerate

   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_load_data),
      .load_ctrl (main_load_ctrl),
      .valid     (main_valid),
      .data      (main_data),
      .ctrl      (main_ctrl)
   );

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

   // Counts backpressure cycles; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1 (4-bit counter) and a SKID=0 instance share
// stimulus; each is checked against a bounded FIFO reference model.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam int DW = MEM_WB_DATA_W;
   localparam int CW = MEM_WB_CTRL_W;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          flush;
   logic          out_ready;

   logic          in_ready1, out_valid1, in_ready0, out_valid0;
   logic [DW-1:0] out_data1, out_data0;
   logic [CW-1:0] out_ctrl1, out_ctrl0;
   logic [3:0]    stall_cnt1;
   logic [15:0]   stall_cnt0;

   int checks   = 0;
   int failures = 0;

   beat_t       q1[$];
   beat_t       q0[$];
   int unsigned cnt1, cnt0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.SKID(1), .CNT_W(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1), .stall_cnt(stall_cnt1)
   );

   pipe_stage_skid #(.SKID(0), .CNT_W(16)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid0),
      .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0), .stall_cnt(stall_cnt0)
   );

   task automatic model_clear();
      q1.delete();
      q0.delete();
      cnt1 = 0;
      cnt0 = 0;
   endtask

   // One clock: the models see a depth-2 / depth-1 FIFO with the same handshake rules.
   task automatic tick();
      bit    ix1, ix0, ox1, ox0, st1, st0, fl;
      beat_t b;
      ix1 = in_valid && (q1.size() < 2);
      ix0 = in_valid && (q0.size() == 0 || out_ready);
      ox1 = (q1.size() > 0) && out_ready;
      ox0 = (q0.size() > 0) && out_ready;
      st1 = (q1.size() > 0) && !out_ready;
      st0 = (q0.size() > 0) && !out_ready;
      fl  = flush;
      b   = '{d: in_data, c: in_ctrl};
      @(posedge clk);
      if (st1 && cnt1 < 15)    cnt1++;
      if (st0 && cnt0 < 65535) cnt0++;
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (ox1) void'(q1.pop_front());
         if (ox0) void'(q0.pop_front());
         if (ix1) q1.push_back(b);
         if (ix0) q0.push_back(b);
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #2;
      reset_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      mem_wb_data_t beat;
      beat      = '{mem_data: 32'hDEADBEEF, alu_result: 32'h0000000A, rd: 5'h05};
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_data   = beat;
      in_ctrl   = 2'b11;
      flush     = 1'b0;
      out_ready = 1'b1;
      #12;
      checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid1); end
      checks++; if (out_ctrl1 !== 2'b00) begin failures++; $display("FAIL rst_out_ctrl got=%b exp=00", out_ctrl1); end
      checks++; if (out_data1 !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data1); end
      checks++; if (stall_cnt1 !== 4'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt1); end
      checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready1); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL rst_out_valid0 got=%b exp=0", out_valid0); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== DW'(beat)) begin
         failures++; $display("FAIL rst_first_beat got=%b/%h exp=1/%h", out_valid1, out_data1, DW'(beat)); end
      checks++; if (out_ctrl0 !== 2'b11 || out_data0 !== DW'(beat)) begin
         failures++; $display("FAIL rst_first_beat0 got=%b/%h exp=11/%h", out_ctrl0, out_data0, DW'(beat)); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid = 1'b1;
      in_data  = DW'(1);
      in_ctrl  = 2'b11;
      tick();
      in_data = DW'(2);
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
         failures++; $display("FAIL mid_rst_valid got=%b%b exp=00", out_valid1, out_valid0); end
      checks++; if (in_ready1 !== 1'b1 || stall_cnt1 !== 4'd0 || out_data1 !== '0) begin
         failures++; $display("FAIL mid_rst_state got=%b/%0d/%h exp=1/0/0", in_ready1, stall_cnt1, out_data1); end
      do_reset();
   endtask

   task automatic test_stream();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         in_ctrl  = 2'b01;
         #1;
         checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            failures++; $display("FAIL stream_in_ready beat=%0d got=%b%b exp=11", i, in_ready1, in_ready0); end
         if (i > 0) begin
            checks++; if (out_valid1 !== 1'b1 || out_data1 !== DW'(i - 1) || out_data0 !== DW'(i - 1)) begin
               failures++; $display("FAIL stream_data beat=%0d got=%h/%h exp=%0d", i, out_data1, out_data0, i - 1); end
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      checks++; if (out_data1 !== DW'(7) || out_data0 !== DW'(7) || out_ctrl1 !== 2'b01) begin
         failures++; $display("FAIL stream_last got=%h/%h ctrl=%b exp=7/7 ctrl=01", out_data1, out_data0, out_ctrl1); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_ctrl   = 2'b01;
      in_data   = DW'(10);
      tick();
      out_ready = 1'b0;
      in_data   = DW'(11);
      #1;
      checks++; if (in_ready1 !== 1'b1 || out_data1 !== DW'(10)) begin
         failures++; $display("FAIL bp_hold10 got=%b/%h exp=1/a", in_ready1, out_data1); end
      tick();
      in_data = DW'(12);
      #1;
      checks++; if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== DW'(10)) begin
         failures++; $display("FAIL bp_full got=%b/%b/%h exp=0/1/a", in_ready1, out_valid1, out_data1); end
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      #1;
      checks++; if (stall_cnt1 !== 4'd4) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=4", stall_cnt1); end
      tick();
      #1;
      checks++; if (out_data1 !== DW'(11) || in_ready1 !== 1'b1) begin
         failures++; $display("FAIL bp_out11 got=%h/%b exp=b/1", out_data1, in_ready1); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_data1 !== DW'(12) || out_valid1 !== 1'b1) begin
         failures++; $display("FAIL bp_out12 got=%h/%b exp=c/1", out_data1, out_valid1); end
      tick();
      #1;
      checks++; if (out_valid1 !== 1'b0 || stall_cnt1 !== 4'd4) begin
         failures++; $display("FAIL bp_drain got=%b/%0d exp=0/4", out_valid1, stall_cnt1); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1;
      in_ctrl  = 2'b11;
      in_data  = DW'(8'hA1);
      tick();
      in_data = DW'(8'hB2);
      tick();
      flush   = 1'b1;
      in_data = DW'(8'h55);
      #1;
      checks++; if (out_ctrl1 !== 2'b11 || in_ready1 !== 1'b0) begin
         failures++; $display("FAIL flush_pre got=%b/%b exp=11/0", out_ctrl1, in_ready1); end
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 2'b00 || in_ready1 !== 1'b1) begin
         failures++; $display("FAIL flush_full got=%b/%b/%b exp=0/00/1", out_valid1, out_ctrl1, in_ready1); end
      checks++; if (out_data1 !== DW'(8'hA1) || out_valid0 !== 1'b0) begin
         failures++; $display("FAIL flush_data_hold got=%h/%b exp=a1/0", out_data1, out_valid0); end
      tick();
      flush    = 1'b1;
      in_valid = 1'b1;
      #1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0 || out_data1 === DW'(8'h55)) begin
         failures++; $display("FAIL flush_discard got=%b/%b/%h exp=0/0/not55", out_valid1, out_valid0, out_data1); end
      tick();
   endtask

   task automatic test_bubble();
      do_reset();
      in_valid = 1'b0;
      in_ctrl  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'($urandom);
         #1;
         checks++; if (out_ctrl1 !== 2'b00 || out_ctrl0 !== 2'b00 || out_valid1 !== 1'b0) begin
            failures++; $display("FAIL bubble_ctrl cyc=%0d got=%b/%b exp=00/00", i, out_ctrl1, out_ctrl0); end
         tick();
      end
   endtask

   task automatic test_saturation();
      do_reset();
      in_valid = 1'b1;
      in_data  = DW'(7);
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      checks++; if (stall_cnt1 !== 4'd15 || stall_cnt0 !== 16'd20) begin
         failures++; $display("FAIL sat_cnt got=%0d/%0d exp=15/20", stall_cnt1, stall_cnt0); end
      repeat (3) tick();
      checks++; if (stall_cnt1 !== 4'd15 || stall_cnt0 !== 16'd23) begin
         failures++; $display("FAIL sat_stick got=%0d/%0d exp=15/23", stall_cnt1, stall_cnt0); end
   endtask

   task automatic test_skid0_comb();
      do_reset();
      in_valid = 1'b1;
      in_data  = DW'(3);
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
         failures++; $display("FAIL skid0_stalled got=%b/%b exp=0/1", in_ready0, out_valid0); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         failures++; $display("FAIL skid0_comb_ready got=%b/%b exp=1/1", in_ready0, in_ready1); end
      tick();
   endtask

   task automatic test_random();
      logic [95:0] r;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         r         = {$urandom, $urandom, $urandom};
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = r[DW-1:0];
         in_ctrl   = CW'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         #1;
         checks++; if (out_valid1 !== (q1.size() > 0) || in_ready1 !== (q1.size() < 2)) begin
            failures++; $display("FAIL rnd_hs1 cyc=%0d got=%b/%b exp=%b/%b", cyc, out_valid1, in_ready1, q1.size() > 0, q1.size() < 2); end
         checks++; if (out_valid0 !== (q0.size() > 0) || in_ready0 !== (q0.size() == 0 || out_ready)) begin
            failures++; $display("FAIL rnd_hs0 cyc=%0d got=%b/%b", cyc, out_valid0, in_ready0); end
         if (q1.size() > 0) begin
            checks++; if (out_data1 !== q1[0].d || out_ctrl1 !== q1[0].c) begin
               failures++; $display("FAIL rnd_data1 cyc=%0d got=%h/%b exp=%h/%b", cyc, out_data1, out_ctrl1, q1[0].d, q1[0].c); end
         end else begin
            checks++; if (out_ctrl1 !== 2'b00) begin failures++; $display("FAIL rnd_bubble1 cyc=%0d got=%b exp=00", cyc, out_ctrl1); end
         end
         if (q0.size() > 0) begin
            checks++; if (out_data0 !== q0[0].d || out_ctrl0 !== q0[0].c) begin
               failures++; $display("FAIL rnd_data0 cyc=%0d got=%h/%b exp=%h/%b", cyc, out_data0, out_ctrl0, q0[0].d, q0[0].c); end
         end
         checks++; if (stall_cnt1 !== 4'(cnt1) || stall_cnt0 !== 16'(cnt0)) begin
            failures++; $display("FAIL rnd_stall cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stall_cnt1, stall_cnt0, cnt1, cnt0); end
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_stream();
      test_backpressure();
      test_flush();
      test_bubble();
      test_saturation();
      test_skid0_comb();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
